fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle processor's decode.
- Walks a sequential PC and issues requests to an instruction memory that has variable latency, over a valid/ready request channel and an in-order response channel.
- Buffers returned words in a small queue and presents {instr, instr_pc} to decode with valid/ready.
- Handles taken-branch redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
ADDR_W, 10, PC / instruction address width (matches the processor's 10-bit pc)
INSTR_W, 16, instruction word width
DEPTH, 4, instruction queue entries; also the cap on (queued + outstanding) requests; power of 2, >=2
RESET_PC, 0, first fetch address after reset

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (reset==0 resets)
mem_req_valid  output  1  request to instruction memory
mem_req_ready  input  1  memory accepts request this cycle
mem_req_addr  output  ADDR_W  fetch address
mem_rsp_valid  input  1  one response per accepted request, in order, >=1 cycle after acceptance
mem_rsp_data  input  INSTR_W  fetched word
redirect_valid  input  1  taken branch from execute; one-cycle pulse
redirect_pc  input  ADDR_W  absolute branch target
instr_valid  output  1  queue head valid
instr  output  INSTR_W  queue head word
instr_pc  output  ADDR_W  address of queue head
instr_ready  input  1  decode consumes head
busy  output  1  state!=FETCH or outstanding!=0

Behaviour:
- Reset (async assert, sync release):
  - mem_req_valid=0, mem_req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, busy=0.
  - Queue empty, outstanding=0, discard=0, state=FETCH.
- States: FETCH, DRAIN.
- FETCH request issue:
  - mem_req_valid=1 when (count + outstanding) < DEPTH; mem_req_addr=fetch_pc.
  - Handshake mem_req_valid&&mem_req_ready: fetch_pc<=fetch_pc+1, wrapping modulo 2^ADDR_W (0x3FF->0x000); outstanding++.
  - mem_req_valid and mem_req_addr stay stable while valid && !ready.
- Responses:
  - Non-stale response (discard==0): word and its address are pushed into the queue; outstanding--.
  - The queue tracks response addresses with an rsp_pc counter incremented per accepted response.
  - Push is visible on instr_* the next cycle (latency: accept->instr_valid >= 2 cycles).
- Pop: instr_valid && instr_ready pops the head. Push and pop in the same cycle are both legal, including when count==DEPTH-1 or the queue is full.
- Full queue: never overflows, because the credit rule forbids issue while count+outstanding==DEPTH.
- mem_rsp_valid with outstanding==0 is a protocol error; the response is ignored.
- Redirect (any state):
  - Queue flushed the same edge and instr_valid=0 the next cycle; a pop in the redirect cycle is ignored.
  - fetch_pc<=redirect_pc; rsp_pc<=redirect_pc.
  - discard <= outstanding minus any response accepted that cycle, plus any request accepted that cycle (that request is stale).
  - No request is issued in the redirect cycle.
  - Next state is DRAIN if the new discard>0, else FETCH.
- DRAIN:
  - mem_req_valid=0.
  - Each mem_rsp_valid decrements discard and outstanding; the data is dropped.
  - discard reaching 0 -> FETCH.
  - A further redirect in DRAIN retargets fetch_pc and rsp_pc and stays in DRAIN.
- Simultaneous redirect and response: the response is treated as stale and dropped.
- Reset mid-transfer: all counters clear. Memory must also be reset; late responses after reset are not tolerated.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the queue is empty, state==FETCH, no redirect, and a non-stale response arrives, the word drives instr/instr_pc/instr_valid combinationally the same cycle.
  - If instr_ready=1, it is consumed without a push. Otherwise it is pushed as normal.
  - Accept->instr_valid latency becomes >=1.
- Undefined: registered path only, as specified above.

Decomposition:
- Package fetch_pkg:
  - ADDR_W_DEF=10, INSTR_W_DEF=16.
  - typedef fetch_state_t {FETCH, DRAIN}.
  - Entry struct {pc, word}.
- One sub-module, fetch_queue: synchronous FIFO of DEPTH entries with push, pop, flush, count, head outputs. Async active-low reset. Pointers wrap at DEPTH.
- Credit, PC and discard logic plus the FSM live in fetch_unit.

Test Plan:
- Reset low then high, memory ready=1, latency 1, instr_ready=1 -> requests 0,1,2,...; instr_pc sequence 0,1,2 with matching words; first instr_valid 2 cycles after first accept.
- instr_ready=0 held -> exactly DEPTH=4 requests (0..3) accepted, then mem_req_valid=0. Release ready -> heads 0..3 pop in order and fetching resumes at 4.
- Memory latency 3, redirect_pc=0x100 while 2 requests are outstanding -> the 2 responses are dropped in DRAIN, next request addr=0x100, first instr_pc=0x100.
- Redirect in the same cycle as a response and a request accept -> both stale words are dropped and no stale instr_pc appears.
- fetch_pc starts at 0x3FE -> addresses 0x3FE, 0x3FF, 0x000 are issued and instr_pc follows them.
- Assert reset low while 3 requests are outstanding -> all outputs return to reset values asynchronously and, after release, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage: default widths, the
// fetch FSM encoding and the queue entry layout {pc, word}.
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int ADDR_W_DEF  = 10;
    localparam int INSTR_W_DEF = 16;

    // FETCH: issuing requests; DRAIN: swallowing responses made stale by a redirect
    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    // One queued instruction: its address in the upper bits, the word below
    typedef struct packed {
        logic [ADDR_W_DEF-1:0]  pc;
        logic [INSTR_W_DEF-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Instruction memory channel: a valid/ready request carrying the fetch
// address and an in-order response (one per accepted request, no back-pressure).
//   master : the fetch unit (drives requests, receives responses)
//   slave  : the instruction memory
// ---------------------------------------------------------------------------
interface fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);

    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [ADDR_W-1:0]  mem_req_addr;
    logic               mem_rsp_valid;
    logic [INSTR_W-1:0] mem_rsp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data
    );

endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Synchronous FIFO of DEPTH entries (DEPTH a power of two, pointers wrap
// naturally). Push and pop may occur together, also when full. flush empties
// the queue; stored data is left in place but is invisible behind count==0.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            drop all entries (wins over push/pop)
//   push, push_data  write one entry at the tail
//   pop              retire the head entry
//   head_data        current head entry (registered storage)
//   count            number of valid entries, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ADDR_W_DEF + INSTR_W_DEF
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                storage_r[wr_ptr_r] <= push_data;
                wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = storage_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage ahead of decode. Walks a sequential PC, issues
// requests to a variable-latency instruction memory, queues the returned
// words with their addresses and hands them to decode with valid/ready.
// A taken-branch redirect flushes the queue, retargets the PC and drains
// every response still in flight at that moment.
//
// Issue is credit based: a request is only offered while
// (queued + outstanding) < DEPTH, so the queue can never overflow.
// mem_req_valid / mem_req_addr / busy are registered from next-state values.
//
// Optional build macro: FETCH_BYPASS_EN
//   When defined, a live response arriving while the queue is empty (and in
//   FETCH, no redirect) is shown to decode combinationally in the same cycle
//   and, if taken, never enters the queue.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   mem               instruction memory channel (fetch_unit_if.master)
//   redirect_valid    one-cycle taken-branch pulse from execute
//   redirect_pc       absolute branch target
//   instr_valid       head of the instruction queue is valid
//   instr, instr_pc   head word and its address
//   instr_ready       decode consumes the head
//   busy              draining, or requests still in flight
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
    input  logic                clk,
    input  logic                reset,
    fetch_unit_if.master        mem,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   instr_pc,
    input  logic                instr_ready,
    output logic                busy
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + INSTR_W;

    localparam logic [0:0] ST_FETCH = FETCH;
    localparam logic [0:0] ST_DRAIN = DRAIN;

    // ---------------- state ----------------
    logic [0:0]        state_r;
    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] rsp_pc_r;
    logic [CNT_W-1:0]  outstanding_r;
    logic [CNT_W-1:0]  discard_r;
    logic              req_valid_r;
    logic              busy_r;

    // ---------------- combinational ----------------
    logic               req_acc_s;
    logic               rsp_acc_s;
    logic               rsp_live_s;
    logic               bypass_s;
    logic               push_s;
    logic               q_pop_s;
    logic [CNT_W-1:0]   q_count_s;
    logic [ENTRY_W-1:0] q_head_s;
    logic [ENTRY_W-1:0] push_data_s;

    logic [CNT_W-1:0]   outstanding_nxt_s;
    logic [CNT_W-1:0]   count_nxt_s;
    logic [CNT_W-1:0]   discard_nxt_s;
    logic [0:0]         state_nxt_s;
    logic [ADDR_W-1:0]  fetch_pc_nxt_s;
    logic [ADDR_W-1:0]  rsp_pc_nxt_s;
    logic [CNT_W:0]     credit_sum_s;
    logic               req_valid_nxt_s;
    logic               busy_nxt_s;

    // Handshake decode. A response with nothing outstanding is a protocol
    // error and is ignored; a response during a redirect or while discarding is stale.
    always_comb begin
        req_acc_s  = req_valid_r && mem.mem_req_ready;
        rsp_acc_s  = mem.mem_rsp_valid && (outstanding_r != '0);
        rsp_live_s = rsp_acc_s && (discard_r == '0) && !redirect_valid;
`ifdef FETCH_BYPASS_EN
        bypass_s   = rsp_live_s && (q_count_s == '0) && (state_r == ST_FETCH);
`else
        bypass_s   = 1'b0;
`endif
        // A bypassed word taken by decode this cycle never enters the queue
        push_s     = rsp_live_s && !(bypass_s && instr_ready);
        // A pop coinciding with a redirect is void: the queue is flushed anyway
        q_pop_s    = (q_count_s != '0) && instr_ready && !redirect_valid;
        push_data_s = {rsp_pc_r, mem.mem_rsp_data};
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .rst_n     (reset),
        .flush     (redirect_valid),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (q_pop_s),
        .head_data (q_head_s),
        .count     (q_count_s)
    );

    // Next-state for counters, PCs and the FSM
    always_comb begin
        outstanding_nxt_s = outstanding_r + CNT_W'(req_acc_s) - CNT_W'(rsp_acc_s);

        if (redirect_valid) begin
            count_nxt_s = '0;
        end else begin
            count_nxt_s = q_count_s + CNT_W'(push_s) - CNT_W'(q_pop_s);
        end

        // On redirect everything still in flight (including a request accepted
        // this very cycle) is stale; otherwise each accepted stale response retires one.
        if (redirect_valid) begin
            discard_nxt_s = outstanding_nxt_s;
        end else if (rsp_acc_s && (discard_r != '0)) begin
            discard_nxt_s = discard_r - CNT_W'(1);
        end else begin
            discard_nxt_s = discard_r;
        end

        case (state_r)
            ST_FETCH: begin
                if (redirect_valid && (discard_nxt_s != '0)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (discard_nxt_s != '0) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            default: state_nxt_s = ST_FETCH;
        endcase

        if (redirect_valid) begin
            fetch_pc_nxt_s = redirect_pc;
        end else if (req_acc_s) begin
            fetch_pc_nxt_s = fetch_pc_r + ADDR_W'(1);
        end else begin
            fetch_pc_nxt_s = fetch_pc_r;
        end

        // rsp_pc advances per live response, also when the word is bypassed
        if (redirect_valid) begin
            rsp_pc_nxt_s = redirect_pc;
        end else if (rsp_live_s) begin
            rsp_pc_nxt_s = rsp_pc_r + ADDR_W'(1);
        end else begin
            rsp_pc_nxt_s = rsp_pc_r;
        end

        // Credit check on next-cycle occupancy; an unaccepted request keeps
        // its credit because the sum can only shrink until it is accepted.
        credit_sum_s    = {1'b0, count_nxt_s} + {1'b0, outstanding_nxt_s};
        req_valid_nxt_s = (state_nxt_s == ST_FETCH) && (credit_sum_s < (CNT_W+1)'(DEPTH));
        busy_nxt_s      = (state_nxt_s != ST_FETCH) || (outstanding_nxt_s != '0);
    end

    // Sequential state of the fetch control
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_FETCH;
            fetch_pc_r    <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= '0;
            discard_r     <= '0;
            req_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            fetch_pc_r    <= fetch_pc_nxt_s;
            rsp_pc_r      <= rsp_pc_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            discard_r     <= discard_nxt_s;
            req_valid_r   <= req_valid_nxt_s;
            busy_r        <= busy_nxt_s;
        end
    end

    // Decode-facing head: the queue, or the in-cycle response when bypassing
    always_comb begin
        if (bypass_s) begin
            instr_valid = 1'b1;
            instr       = mem.mem_rsp_data;
            instr_pc    = rsp_pc_r;
        end else begin
            instr_valid = (q_count_s != '0);
            instr       = q_head_s[INSTR_W-1:0];
            instr_pc    = q_head_s[ENTRY_W-1:INSTR_W];
        end
    end

    assign mem.mem_req_valid = req_valid_r;
    assign mem.mem_req_addr  = fetch_pc_r;
    assign busy              = busy_r;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. A fixed-latency in-order memory model lives
// in the tick task; every word returned is {6'h2A, addr} so each popped
// instruction can be matched against its address.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int AW = 10;
    localparam int IW = 16;
`ifdef FETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic          clk;
    logic          reset;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;
    logic          busy;

    fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) mem_bus ();

    fetch_unit #(
        .ADDR_W   (AW),
        .INSTR_W  (IW),
        .DEPTH    (4),
        .RESET_PC (10'h000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem            (mem_bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .busy           (busy)
    );

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } pend_t;

    int               errors = 0;
    int               checks = 0;
    int               cyc    = 0;
    int               lat    = 1;
    pend_t            pend[$];
    logic [AW+IW-1:0] got[$];
    logic [AW-1:0]    acc[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [IW-1:0] word_of(input logic [AW-1:0] a);
        return {6'h2A, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_got(input string tag, input int idx, input logic [AW-1:0] exp_pc);
        logic [AW+IW-1:0] obs;
        obs = (idx < got.size()) ? got[idx] : {(AW+IW){1'bx}};
        chk(tag, {6'h00, obs}, {6'h00, exp_pc, word_of(exp_pc)});
    endtask

    task automatic chk_acc(input string tag, input int idx, input logic [AW-1:0] exp_addr);
        logic [AW-1:0] obs;
        obs = (idx < acc.size()) ? acc[idx] : {AW{1'bx}};
        chk(tag, {22'h0, obs}, {22'h0, exp_addr});
    endtask

    // One clock cycle: log handshakes of the ending cycle, advance, present memory response
    task automatic tick();
        if (mem_bus.mem_rsp_valid && (pend.size() > 0)) begin
            void'(pend.pop_front());
        end
        if (mem_bus.mem_req_valid && mem_bus.mem_req_ready) begin
            pend.push_back('{addr: mem_bus.mem_req_addr, due: cyc + lat});
            acc.push_back(mem_bus.mem_req_addr);
        end
        if (instr_valid && instr_ready && !redirect_valid) begin
            got.push_back({instr_pc, instr});
        end
        @(posedge clk);
        #1;
        cyc++;
        if ((pend.size() > 0) && (pend[0].due <= cyc)) begin
            mem_bus.mem_rsp_valid = 1'b1;
            mem_bus.mem_rsp_data  = word_of(pend[0].addr);
        end else begin
            mem_bus.mem_rsp_valid = 1'b0;
            mem_bus.mem_rsp_data  = 16'h0000;
        end
        #1;
    endtask

    task automatic mem_clear();
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rsp_data  = 16'h0000;
        pend.delete();
        got.delete();
        acc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        redirect_valid = 1'b0;
        #1;
        mem_clear();
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset                 = 1'b1;
        redirect_valid        = 1'b0;
        redirect_pc           = 10'h000;
        instr_ready           = 1'b1;
        mem_bus.mem_req_ready = 1'b1;
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rsp_data  = 16'h0000;

        // Reset values, asserted asynchronously before any clock edge
        #2 reset = 1'b0;
        #1;
        chk("rst_req_valid",   {31'h0, mem_bus.mem_req_valid}, 32'h0);
        chk("rst_req_addr",    {22'h0, mem_bus.mem_req_addr},  32'h0);
        chk("rst_instr_valid", {31'h0, instr_valid},           32'h0);
        chk("rst_instr",       {16'h0, instr},                 32'h0);
        chk("rst_instr_pc",    {22'h0, instr_pc},              32'h0);
        chk("rst_busy",        {31'h0, busy},                  32'h0);
        tick();
        tick();
        reset = 1'b1;

        // 1: streaming, latency 1, decode always ready
        lat = 1;
        tick();
        chk("t1_req_valid", {31'h0, mem_bus.mem_req_valid}, 32'h1);
        chk("t1_addr0",     {22'h0, mem_bus.mem_req_addr},  32'h000);
        tick();
        chk("t1_addr1",     {22'h0, mem_bus.mem_req_addr},  32'h001);
        chk("t1_valid_c2",  {31'h0, instr_valid},           BYP);
        tick();
        chk("t1_valid_c3",  {31'h0, instr_valid},           32'h1);
        chk("t1_pc_c3",     {22'h0, instr_pc},              BYP);
        chk("t1_word_c3",   {16'h0, instr},                 {16'h0, word_of(10'(BYP))});
        repeat (6) tick();
        for (int i = 0; i < 5; i++) begin
            chk_got("t1_seq", i, 10'(i));
        end
        chk_acc("t1_acc5", 5, 10'h005);

        // 2: decode stalled -> credit limit of 4 requests, then release
        do_reset();
        instr_ready = 1'b0;
        repeat (10) tick();
        chk("t2_acc_cnt",    acc.size(),                      32'd4);
        chk_acc("t2_acc3", 3, 10'h003);
        chk("t2_req_idle",   {31'h0, mem_bus.mem_req_valid},  32'h0);
        chk("t2_head_valid", {31'h0, instr_valid},            32'h1);
        chk("t2_head_pc",    {22'h0, instr_pc},               32'h000);
        chk("t2_busy",       {31'h0, busy},                   32'h0);
        instr_ready = 1'b1;
        repeat (8) tick();
        for (int i = 0; i < 5; i++) begin
            chk_got("t2_seq", i, 10'(i));
        end
        chk_acc("t2_resume", 4, 10'h004);

        // 3: latency 3, redirect with two requests outstanding
        do_reset();
        lat = 3;
        tick();
        tick();
        tick();
        chk("t3_busy_pre", {31'h0, busy}, 32'h1);
        mem_bus.mem_req_ready = 1'b0;
        redirect_valid        = 1'b1;
        redirect_pc           = 10'h100;
        tick();
        redirect_valid        = 1'b0;
        mem_bus.mem_req_ready = 1'b1;
        chk("t3_drain_req",   {31'h0, mem_bus.mem_req_valid}, 32'h0);
        chk("t3_drain_busy",  {31'h0, busy},                  32'h1);
        chk("t3_drain_valid", {31'h0, instr_valid},           32'h0);
        tick();
        tick();
        chk("t3_req_valid", {31'h0, mem_bus.mem_req_valid}, 32'h1);
        chk("t3_req_addr",  {22'h0, mem_bus.mem_req_addr},  32'h100);
        repeat (8) tick();
        chk_got("t3_first", 0, 10'h100);
        chk_got("t3_second", 1, 10'h101);

        // 4: redirect coinciding with a response and a request accept
        do_reset();
        lat = 1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 10'h200;
        tick();
        redirect_valid = 1'b0;
        chk("t4_drain_req",   {31'h0, mem_bus.mem_req_valid}, 32'h0);
        chk("t4_drain_busy",  {31'h0, busy},                  32'h1);
        chk("t4_drain_valid", {31'h0, instr_valid},           32'h0);
        tick();
        chk("t4_req_valid", {31'h0, mem_bus.mem_req_valid}, 32'h1);
        chk("t4_req_addr",  {22'h0, mem_bus.mem_req_addr},  32'h200);
        repeat (6) tick();
        chk_got("t4_first", 0, 10'h200);
        chk_got("t4_second", 1, 10'h201);

        // 5: PC wrap 0x3FE -> 0x3FF -> 0x000
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 10'h3FE;
        tick();
        redirect_valid = 1'b0;
        chk("t5_req_addr", {22'h0, mem_bus.mem_req_addr}, 32'h3FE);
        repeat (8) tick();
        chk_acc("t5_acc0", 0, 10'h3FE);
        chk_acc("t5_acc1", 1, 10'h3FF);
        chk_acc("t5_acc2", 2, 10'h000);
        chk_got("t5_got0", 0, 10'h3FE);
        chk_got("t5_got1", 1, 10'h3FF);
        chk_got("t5_got2", 2, 10'h000);

        // 6: asynchronous reset with three requests outstanding
        do_reset();
        lat = 4;
        repeat (4) tick();
        chk("t6_busy_pre", {31'h0, busy}, 32'h1);
        reset = 1'b0;
        #1;
        chk("t6_rst_req_valid",   {31'h0, mem_bus.mem_req_valid}, 32'h0);
        chk("t6_rst_req_addr",    {22'h0, mem_bus.mem_req_addr},  32'h000);
        chk("t6_rst_instr_valid", {31'h0, instr_valid},           32'h0);
        chk("t6_rst_busy",        {31'h0, busy},                  32'h0);
        mem_clear();
        tick();
        reset = 1'b1;
        tick();
        chk("t6_req_valid", {31'h0, mem_bus.mem_req_valid}, 32'h1);
        chk("t6_req_addr",  {22'h0, mem_bus.mem_req_addr},  32'h000);
        repeat (7) tick();
        chk_got("t6_first", 0, 10'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
